// File: rtl/grid_peel_pkg.sv
// Shared FSM state type and width helpers for grid_peel_engine.
// GRID_PEEL_READBACK_EN adds the READBACK state used to stream out the final grid.
package grid_peel_pkg;

`ifdef GRID_PEEL_READBACK_EN
   typedef enum logic [1:0] {StLoad, StSweep, StReport, StReadback} peel_state_e;
`else
   typedef enum logic [1:0] {StLoad, StSweep, StReport} peel_state_e;
`endif

   function automatic int unsigned cnt_w(input int unsigned width, input int unsigned depth);
      return $clog2(width * depth + 1);
   endfunction

   function automatic int unsigned idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/grid_peel_engine_peel_sweep.sv
// One snapshot sweep: clears every occupied cell with fewer than THRESH occupied
// 8-neighbours and reports how many cells were cleared.
module peel_sweep
   import grid_peel_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned THRESH = 4,
   parameter int unsigned CNT_W  = cnt_w(WIDTH, DEPTH)
) (
   input  logic [DEPTH-1:0][WIDTH-1:0] grid_i,
   output logic [DEPTH-1:0][WIDTH-1:0] grid_o,
   output logic [CNT_W-1:0]            removed_o
);

   // Zero ring around the grid so border cells see empty neighbours.
   logic [DEPTH+1:0][WIDTH+1:0] padded;
   logic [3:0]                  nbrs;

   always_comb begin
      padded = '0;
      for (int r = 0; r < DEPTH; r++) begin
         padded[r+1][WIDTH:1] = grid_i[r];
      end
   end

   always_comb begin
      grid_o    = grid_i;
      removed_o = '0;
      nbrs      = '0;
      for (int r = 0; r < DEPTH; r++) begin
         for (int c = 0; c < WIDTH; c++) begin
            nbrs = '0;
            for (int dr = 0; dr < 3; dr++) begin
               for (int dc = 0; dc < 3; dc++) begin
                  if (!(dr == 1 && dc == 1)) begin
                     nbrs = nbrs + 4'(padded[r+dr][c+dc]);
                  end
               end
            end
            if (grid_i[r][c] && (32'(nbrs) < THRESH)) begin
               grid_o[r][c] = 1'b0;
               removed_o    = removed_o + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/grid_peel_engine.sv
// Loads a DEPTH x WIDTH occupancy grid, peels accessible cells one sweep per cycle
// until stable or MAX_SWEEPS, then reports counts. GRID_PEEL_READBACK_EN adds rd_* readback.
module grid_peel_engine
   import grid_peel_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned THRESH     = 4,
   parameter int unsigned MAX_SWEEPS = 255,
   localparam int unsigned CNT_W     = cnt_w(WIDTH, DEPTH),
   localparam int unsigned SW_W      = $clog2(MAX_SWEEPS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_row,
`ifdef GRID_PEEL_READBACK_EN
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_row,
`endif
   output logic             done,
   output logic             busy,
   output logic [CNT_W-1:0] first_cnt,
   output logic [CNT_W-1:0] total_cnt,
   output logic [SW_W-1:0]  sweeps,
   output logic             limit_hit
);

   localparam int unsigned      IDX_W   = idx_w(DEPTH);
   localparam logic [IDX_W-1:0] LastRow = IDX_W'(DEPTH - 1);
   localparam logic [SW_W-1:0]  MaxSw   = SW_W'(MAX_SWEEPS);

   peel_state_e                 state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [DEPTH-1:0][WIDTH-1:0] grid_q, grid_d, grid_next;
   logic [CNT_W-1:0]            first_q, first_d, total_q, total_d, removed;
   logic [SW_W-1:0]             sweeps_q, sweeps_d;
   logic                        limit_q, limit_d;

   peel_sweep #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .THRESH (THRESH),
      .CNT_W  (CNT_W)
   ) u_sweep (
      .grid_i    (grid_q),
      .grid_o    (grid_next),
      .removed_o (removed)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      grid_d   = grid_q;
      first_d  = first_q;
      total_d  = total_q;
      sweeps_d = sweeps_q;
      limit_d  = limit_q;
      in_ready = 1'b0;
      done     = 1'b0;
`ifdef GRID_PEEL_READBACK_EN
      rd_valid = 1'b0;
      rd_row   = grid_q[idx_q];
`endif
      unique case (state_q)
         StLoad: begin
            in_ready = 1'b1;
            if (in_valid) begin
               grid_d[idx_q] = in_row;
               if (idx_q == LastRow) begin
                  // Previous results stay visible until the new grid is complete.
                  idx_d    = '0;
                  first_d  = '0;
                  total_d  = '0;
                  sweeps_d = '0;
                  limit_d  = 1'b0;
                  state_d  = StSweep;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         StSweep: begin
            if (removed == '0) begin
               state_d = StReport;
            end else begin
               grid_d   = grid_next;
               total_d  = total_q + removed;
               sweeps_d = sweeps_q + SW_W'(1);
               if (sweeps_q == '0) begin
                  first_d = removed;
               end
               if (sweeps_d == MaxSw) begin
                  limit_d = 1'b1;
                  state_d = StReport;
               end
            end
         end
         StReport: begin
            done = 1'b1;
`ifdef GRID_PEEL_READBACK_EN
            state_d = StReadback;
`else
            state_d = StLoad;
`endif
         end
`ifdef GRID_PEEL_READBACK_EN
         StReadback: begin
            rd_valid = 1'b1;
            if (rd_ready) begin
               if (idx_q == LastRow) begin
                  idx_d   = '0;
                  state_d = StLoad;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
`endif
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StLoad;
         idx_q    <= '0;
         grid_q   <= '0;
         first_q  <= '0;
         total_q  <= '0;
         sweeps_q <= '0;
         limit_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         grid_q   <= grid_d;
         first_q  <= first_d;
         total_q  <= total_d;
         sweeps_q <= sweeps_d;
         limit_q  <= limit_d;
      end
   end

   assign busy      = (state_q == StSweep) || ((state_q == StLoad) && (idx_q != '0));
   assign first_cnt = first_q;
   assign total_cnt = total_q;
   assign sweeps    = sweeps_q;
   assign limit_hit = limit_q;

endmodule

// File: tb/tb_grid_peel_engine.sv
// Self-checking bench for grid_peel_engine: four parameterisations checked against a
// list-based peeling model, with literal expectations pinning the model.
module tb_grid_peel_engine;

   localparam int NI = 4;

   logic        clk;
   logic        rst_n;
   logic [15:0] row_bus;
   logic        iv  [NI];
   logic        rdy [NI];
   logic        dn  [NI];
   logic        bsy [NI];
   logic        lim [NI];
   logic [31:0] fc  [NI];
   logic [31:0] tc  [NI];
   logic [31:0] sw  [NI];

   logic [8:0] fc0, tc0;
   logic [7:0] sw0;
   logic [6:0] fc1, tc1;
   logic [7:0] sw1;
   logic [3:0] fc2, tc2;
   logic [7:0] sw2;
   logic [3:0] fc3, tc3;
   logic [1:0] sw3;

   assign fc[0] = 32'(fc0);
   assign tc[0] = 32'(tc0);
   assign sw[0] = 32'(sw0);
   assign fc[1] = 32'(fc1);
   assign tc[1] = 32'(tc1);
   assign sw[1] = 32'(sw1);
   assign fc[2] = 32'(fc2);
   assign tc[2] = 32'(tc2);
   assign sw[2] = 32'(sw2);
   assign fc[3] = 32'(fc3);
   assign tc[3] = 32'(tc3);
   assign sw[3] = 32'(sw3);

`ifdef GRID_PEEL_READBACK_EN
   logic        rv [NI];
   logic [15:0] rr0;
   logic [9:0]  rr1;
   logic [2:0]  rr2, rr3;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   grid_peel_engine #(.WIDTH(16), .DEPTH(16), .THRESH(4), .MAX_SWEEPS(255)) u_g16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_row(row_bus),
`ifdef GRID_PEEL_READBACK_EN
      .rd_valid(rv[0]), .rd_ready(1'b1), .rd_row(rr0),
`endif
      .done(dn[0]), .busy(bsy[0]), .first_cnt(fc0), .total_cnt(tc0), .sweeps(sw0),
      .limit_hit(lim[0]));

   grid_peel_engine #(.WIDTH(10), .DEPTH(10), .THRESH(4), .MAX_SWEEPS(255)) u_g10 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_row(row_bus[9:0]),
`ifdef GRID_PEEL_READBACK_EN
      .rd_valid(rv[1]), .rd_ready(1'b1), .rd_row(rr1),
`endif
      .done(dn[1]), .busy(bsy[1]), .first_cnt(fc1), .total_cnt(tc1), .sweeps(sw1),
      .limit_hit(lim[1]));

   grid_peel_engine #(.WIDTH(3), .DEPTH(3), .THRESH(4), .MAX_SWEEPS(255)) u_g3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]), .in_row(row_bus[2:0]),
`ifdef GRID_PEEL_READBACK_EN
      .rd_valid(rv[2]), .rd_ready(1'b1), .rd_row(rr2),
`endif
      .done(dn[2]), .busy(bsy[2]), .first_cnt(fc2), .total_cnt(tc2), .sweeps(sw2),
      .limit_hit(lim[2]));

   grid_peel_engine #(.WIDTH(3), .DEPTH(3), .THRESH(4), .MAX_SWEEPS(2)) u_g3l (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(rdy[3]), .in_row(row_bus[2:0]),
`ifdef GRID_PEEL_READBACK_EN
      .rd_valid(rv[3]), .rd_ready(1'b1), .rd_row(rr3),
`endif
      .done(dn[3]), .busy(bsy[3]), .first_cnt(fc3), .total_cnt(tc3), .sweeps(sw3),
      .limit_hit(lim[3]));

   int          checks = 0;
   int          errors = 0;
   int          wd     [NI];
   int          mx     [NI];
   int          exp_f  [NI];
   int          exp_t  [NI];
   int          exp_s  [NI];
   int          exp_l  [NI];
   bit          armed  [NI];
   bit          hold   [NI];
   logic [15:0] grid   [16];

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Repeatedly collect every accessible cell into a list, then clear the whole list.
   function automatic void peel_model(input logic [15:0] g [16], input int w, input int d,
                                      input int maxsw, output int first, output int total,
                                      output int nsw, output int limh, output int ncyc);
      logic [15:0] cur [16];
      int          qr [$];
      int          qc [$];
      int          cnt;
      cur   = g;
      first = 0;
      total = 0;
      nsw   = 0;
      limh  = 0;
      ncyc  = 0;
      for (int it = 0; it < 1000; it++) begin
         ncyc++;
         qr.delete();
         qc.delete();
         for (int r = 0; r < d; r++) begin
            for (int c = 0; c < w; c++) begin
               if (cur[r][c]) begin
                  cnt = 0;
                  for (int dr = -1; dr <= 1; dr++) begin
                     for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < d &&
                            c + dc >= 0 && c + dc < w) begin
                           if (cur[r+dr][c+dc]) cnt++;
                        end
                     end
                  end
                  if (cnt < 4) begin
                     qr.push_back(r);
                     qc.push_back(c);
                  end
               end
            end
         end
         if (qr.size() == 0) break;
         foreach (qr[i]) cur[qr[i]][qc[i]] = 1'b0;
         if (nsw == 0) first = qr.size();
         total += qr.size();
         nsw++;
         if (nsw == maxsw) begin
            limh = 1;
            break;
         end
      end
   endfunction

   function automatic void clear_grid();
      foreach (grid[r]) grid[r] = '0;
   endfunction

   function automatic void set_row(input int r, input string s);
      grid[r] = '0;
      for (int c = 0; c < s.len(); c++) begin
         if (s[c] == 8'h40) grid[r][c] = 1'b1;
      end
   endfunction

   function automatic void set_puzzle();
      clear_grid();
      set_row(0, "..@@.@@@@.");
      set_row(1, "@@@.@.@.@@");
      set_row(2, "@@@@@.@.@@");
      set_row(3, "@.@@@@..@.");
      set_row(4, "@@.@@@@.@@");
      set_row(5, ".@@@@@@@.@");
      set_row(6, ".@.@.@.@@@");
      set_row(7, "@.@@@.@@@@");
      set_row(8, ".@@@@@@@@.");
      set_row(9, "@.@.@@@.@.");
   endfunction

   function automatic void set_ones3();
      clear_grid();
      for (int r = 0; r < 3; r++) grid[r] = 16'h0007;
   endfunction

   int acc [NI];
   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (iv[k] && rdy[k]) acc[k] <= acc[k] + 1;
      end
   end

   // Compare process: results at every done pulse, and held results afterwards.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            if (dn[k]) begin
               if (armed[k]) begin
                  chk($sformatf("u%0d first_cnt", k), int'(fc[k]), exp_f[k]);
                  chk($sformatf("u%0d total_cnt", k), int'(tc[k]), exp_t[k]);
                  chk($sformatf("u%0d sweeps", k), int'(sw[k]), exp_s[k]);
                  chk($sformatf("u%0d limit_hit", k), int'(lim[k]), exp_l[k]);
                  armed[k] = 1'b0;
               end else begin
                  chk($sformatf("u%0d unexpected done", k), 1, 0);
               end
            end else if (hold[k]) begin
               chk($sformatf("u%0d held total_cnt", k), int'(tc[k]), exp_t[k]);
               chk($sformatf("u%0d held sweeps", k), int'(sw[k]), exp_s[k]);
            end
         end
      end
   end

   task automatic load(input int k, input bit toggle);
      int r;
      int cyc;
      r      = 0;
      cyc    = 0;
      hold[k] = 1'b0;
      acc[k] = 0;
      while (r < wd[k] && cyc < 400) begin
         @(negedge clk);
         cyc++;
         chk($sformatf("u%0d busy during load", k), int'(bsy[k]), (r > 0) ? 1 : 0);
         if (toggle && (cyc % 2 == 0)) begin
            iv[k] = 1'b0;
         end else begin
            iv[k]   = 1'b1;
            row_bus = grid[r];
            if (rdy[k]) r++;
         end
      end
      @(negedge clk);
      iv[k] = 1'b0;
      chk($sformatf("u%0d rows accepted", k), acc[k], wd[k]);
      chk($sformatf("u%0d in_ready after load", k), int'(rdy[k]), 0);
      chk($sformatf("u%0d busy after load", k), int'(bsy[k]), 1);
   endtask

   task automatic run(input int k, input bit toggle);
      int ef, et, es, el, ec, cyc;
      peel_model(grid, wd[k], wd[k], mx[k], ef, et, es, el, ec);
      exp_f[k] = ef;
      exp_t[k] = et;
      exp_s[k] = es;
      exp_l[k] = el;
      armed[k] = 1'b1;
      load(k, toggle);
      cyc = 1;
      while (!dn[k] && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("u%0d done latency", k), cyc, ec + 1);
      @(negedge clk);
      hold[k] = 1'b1;
      chk($sformatf("u%0d busy after done", k), int'(bsy[k]), 0);
`ifndef GRID_PEEL_READBACK_EN
      chk($sformatf("u%0d in_ready after done", k), int'(rdy[k]), 1);
`endif
      repeat (3) @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("%s u%0d in_ready", tag, k), int'(rdy[k]), 1);
         chk($sformatf("%s u%0d done", tag, k), int'(dn[k]), 0);
         chk($sformatf("%s u%0d busy", tag, k), int'(bsy[k]), 0);
         chk($sformatf("%s u%0d first_cnt", tag, k), int'(fc[k]), 0);
         chk($sformatf("%s u%0d total_cnt", tag, k), int'(tc[k]), 0);
         chk($sformatf("%s u%0d sweeps", tag, k), int'(sw[k]), 0);
         chk($sformatf("%s u%0d limit_hit", tag, k), int'(lim[k]), 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ef, et, es, el, ec, cyc;
      wd = '{16, 10, 3, 3};
      mx = '{255, 255, 255, 2};
      for (int k = 0; k < NI; k++) begin
         iv[k]    = 1'b0;
         armed[k] = 1'b0;
         hold[k]  = 1'b0;
         acc[k]   = 0;
      end
      row_bus = '0;
      clear_grid();
      rst_n = 1'b0;
      #1;
      check_idle("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Literal expectations that pin the model.
      set_puzzle();
      peel_model(grid, 10, 10, 255, ef, et, es, el, ec);
      chk("model puzzle first", ef, 13);
      chk("model puzzle total", et, 43);
      chk("model puzzle limit", el, 0);
      set_ones3();
      peel_model(grid, 3, 3, 255, ef, et, es, el, ec);
      chk("model ones3 first", ef, 4);
      chk("model ones3 total", et, 9);
      chk("model ones3 sweeps", es, 3);
      chk("model ones3 limit", el, 0);
      peel_model(grid, 3, 3, 2, ef, et, es, el, ec);
      chk("model ones3 lim total", et, 8);
      chk("model ones3 lim sweeps", es, 2);
      chk("model ones3 lim limit", el, 1);
      clear_grid();
      peel_model(grid, 16, 16, 255, ef, et, es, el, ec);
      chk("model empty total", et, 0);
      chk("model empty cycles", ec, 1);

      set_puzzle();
      run(1, 1'b0);
      run(1, 1'b1);
      set_ones3();
      run(2, 1'b0);
      run(3, 1'b0);
      clear_grid();
      run(0, 1'b0);
      foreach (grid[r]) grid[r] = 16'hffff;
      run(0, 1'b0);
      set_puzzle();
      run(0, 1'b1);

      // Reset during the second sweep of a three-sweep grid.
      for (int k = 0; k < NI; k++) hold[k] = 1'b0;
      set_ones3();
      armed[0] = 1'b0;
      load(0, 1'b0);
      cyc = 1;
      while (sw[0] != 1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("reset test reached sweep 2", cyc, 2);
      rst_n = 1'b0;
      #1;
      check_idle("mid-sweep reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("post-reset u0 in_ready", int'(rdy[0]), 1);
      chk("post-reset u0 sweeps", int'(sw[0]), 0);
      set_puzzle();
      run(0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
